// File: rtl/mem_arbiter_if.sv
// Bus bundle between the LC-3 memory users (CPU port, debug/loader port)
// and the shared single-port RAM. The arbiter sits on the slave modport;
// whatever drives the requests and models the RAM uses the master modport.
interface mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          cpu_halt;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ready;

  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic [DW-1:0] dbg_rdata;
  logic          dbg_ack;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_halt, cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_halt, cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbiter sharing the single-port LC-3 RAM between the CPU memory port and
// the debug/program-loader port. Each access walks IDLE -> ACCESS -> WAIT ->
// RESP, so every access (read or write) has the same fixed latency.
// CPU wins by default; the loader wins while the CPU is halted.
// Optional: define MEM_ARB_STARVE_GUARD_EN to force a loader grant after
// STARVE consecutive CPU grants taken while the loader was waiting.
module mem_arbiter #(
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int RD_LAT = 1,
  parameter int STARVE = 4
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  // Catch illegal configurations at elaboration; the counters are 3 bits wide.
  if (RD_LAT < 1 || RD_LAT > 7) begin : g_badRdLat
    $error("mem_arbiter: RD_LAT must be within 1..7");
  end
  if (STARVE < 1 || STARVE > 7) begin : g_badStarve
    $error("mem_arbiter: STARVE must be within 1..7");
  end

  localparam logic [2:0] LAT_INIT = 3'(RD_LAT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arbState_t;

  arbState_t     r_state;
  arbState_t     w_nextState;
  logic          r_owner;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_cpuRdata;
  logic [DW-1:0] r_dbgRdata;
  logic [2:0]    r_latCnt;
  logic          w_grant;
  logic          w_grantDbg;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [2:0] STARVE_LIM = 3'(STARVE);

  logic [2:0] r_starveCnt;
  logic       w_starveHit;

  assign w_starveHit = (r_starveCnt >= STARVE_LIM);

  // Count CPU grants taken while the loader waits; any loader grant or an idle loader clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starveCnt <= 3'd0;
    end else if (r_state == IDLE) begin
      if (!bus.dbg_req) begin
        r_starveCnt <= 3'd0;
      end else if (w_grant && w_grantDbg) begin
        r_starveCnt <= 3'd0;
      end else if (w_grant) begin
        r_starveCnt <= r_starveCnt + 3'd1;
      end
    end
  end
`endif

  // Grant decision, only acted on in IDLE: halted CPU yields, else CPU first, else loader.
  always_comb begin
    w_grant    = 1'b0;
    w_grantDbg = 1'b0;
    if (bus.cpu_halt && bus.dbg_req) begin
      w_grant    = 1'b1;
      w_grantDbg = 1'b1;
    end
`ifdef MEM_ARB_STARVE_GUARD_EN
    else if (w_starveHit && bus.dbg_req) begin
      w_grant    = 1'b1;
      w_grantDbg = 1'b1;
    end
`endif
    else if (bus.cpu_req) begin
      w_grant = 1'b1;
    end else if (bus.dbg_req) begin
      w_grant    = 1'b1;
      w_grantDbg = 1'b1;
    end
  end

  // Next-state sequencing of one access; WAIT lasts RD_LAT cycles.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_nextState = ACCESS;
      ACCESS:  w_nextState = WAIT;
      WAIT:    if (r_latCnt == 3'd1) w_nextState = RESP;
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // State register; an async reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Latch the granted request, run the latency counter and capture read data for the owner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner    <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cpuRdata <= '0;
      r_dbgRdata <= '0;
      r_latCnt   <= 3'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_owner <= w_grantDbg;
            r_we    <= w_grantDbg ? bus.dbg_we    : bus.cpu_we;
            r_addr  <= w_grantDbg ? bus.dbg_addr  : bus.cpu_addr;
            r_wdata <= w_grantDbg ? bus.dbg_wdata : bus.cpu_wdata;
          end
        end
        ACCESS: begin
          r_latCnt <= LAT_INIT;
        end
        WAIT: begin
          r_latCnt <= r_latCnt - 3'd1;
          if (r_latCnt == 3'd1 && !r_we) begin
            if (r_owner) begin
              r_dbgRdata <= bus.mem_rdata;
            end else begin
              r_cpuRdata <= bus.mem_rdata;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.mem_en    = (r_state == ACCESS);
  assign bus.mem_we    = (r_state == ACCESS) && r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.cpu_ready = (r_state == RESP) && !r_owner;
  assign bus.dbg_ack   = (r_state == RESP) && r_owner;
  assign bus.cpu_rdata = r_cpuRdata;
  assign bus.dbg_rdata = r_dbgRdata;

endmodule
